tcm_axi_loader: RTL and testbench
=================================

// Module: tcm_axi_loader
// PURPOSE
//  Upstream AXI4 write master feeding the TCM's external AXI slave port.
//  Takes a byte stream (boot UART / debug bridge), packs little-endian 32-bit words,
//  buffers up to BURST_LEN words, issues INCR write bursts from a base address.
//  Used to load firmware into TCM before CPU reset release.
// PARAMETERS
//  BURST_LEN  8    words per burst; power of 2, 1..16; word buffer depth
//  AXI_ID     0    4-bit value driven on axi_awid_o
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   reset, asynchronous, active-low
//  start_i         in   1   begin load (sampled only in IDLE)
//  base_addr_i     in   32  load base; [1:0] ignored; latched on start
//  len_i           in   16  load length in bytes; latched on start
//  byte_valid_i    in   1   stream byte valid
//  byte_data_i     in   8   stream byte
//  byte_ready_o    out  1   stream byte accepted when valid&&ready
//  busy_o          out  1   load in progress
//  done_o          out  1   1-cycle pulse at end of load
//  error_o         out  1   sticky: a burst returned bresp!=OKAY; cleared on start
//  axi_awvalid_o   out  1   / axi_awaddr_o out 32 / axi_awid_o out 4
//  axi_awlen_o     out  8   beats-1 / axi_awburst_o out 2 (always 2'b01 INCR)
//  axi_awready_i   in   1
//  axi_wvalid_o    out  1   / axi_wdata_o out 32 / axi_wstrb_o out 4 / axi_wlast_o out 1
//  axi_wready_i    in   1
//  axi_bvalid_i    in   1   / axi_bresp_i in 2 / axi_bid_i in 4 (ignored)
//  axi_bready_o    out  1
// BEHAVIOUR
//  Reset: all outputs 0 except axi_awburst_o=2'b01, axi_awid_o=AXI_ID; FSM->IDLE,
//   counters, buffer, error cleared. Reset mid-burst drops valids immediately.
//  FSM: IDLE -> FILL -> AW -> W -> B -> (FILL | DONE) ; DONE -> IDLE.
//  IDLE: start_i=1 latches base/len, clears error_o; len_i==0 -> DONE (no AXI traffic),
//   else FILL. busy_o=1 in every state except IDLE. start_i outside IDLE ignored.
//  FILL: byte_ready_o=1. Bytes packed LSB-first: byte k of word at bits [8k+7:8k].
//   Word pushed when 4 bytes packed or when last byte of len_i arrives (partial).
//   Leave to AW when buffer holds BURST_LEN words or final word pushed.
//  AW: axi_awvalid_o=1, awaddr = word-aligned base + 4*words_sent, awlen = words_buffered-1.
//   awvalid held stable until awready; then W. W only starts after AW handshake.
//  W: beats drained in order; axi_wvalid_o=1, wdata stable until wready.
//   wstrb=4'hF except final word of load: wstrb = (len%4==0)?F : (1<<(len%4))-1.
//   wlast=1 on beat awlen. byte_ready_o=0 in AW/W/B (no fill during burst).
//  B: axi_bready_o=1. On bvalid: bresp!=2'b00 -> error_o=1, go DONE (abort remainder);
//   else FILL if bytes remain, else DONE.
//  DONE: done_o=1 for exactly one cycle, next cycle IDLE (busy_o=0).
//  Latency: done_o asserts the cycle after the final B handshake.
//  Address wrap: awaddr 32-bit modulo; no 4KB check (TCM is 64KB, base assumed aligned
//   to BURST_LEN*4 by software; misaligned base still legal, bursts just straddle).
//  Counters: byte counter 16-bit; max load 65535 bytes.
// CONFIGURATION
//  TCM_LOADER_CSUM_EN defined: adds output csum_o [31:0] = 32-bit wrapping sum of every
//   word written (partial final word with unwritten bytes zero); cleared on start,
//   updated on each W handshake, stable after done_o.
//  Undefined: no csum_o port, no adder logic.
// TESTING
//  T1 len=8, base=0x100, bytes 01..08, ready always -> one AW addr 0x100 len 1;
//     W 0x04030201 strb F, 0x08070605 strb F wlast; done_o 1 cycle after B.
//  T2 len=6 -> last beat wdata 0x00000605 wstrb 4'b0011, wlast=1.
//  T3 BURST_LEN=8, len=80 -> 3 bursts: awaddr base,+0x20,+0x40; awlen 7,7,3.
//  T4 bresp=2'b10 on burst 1 of 3 -> error_o=1, no further AW, done_o pulses.
//  T5 awready/wready randomly low 50% -> awaddr/wdata stable while stalled; data intact.
//  T6 len=0 -> done_o 1 cycle after start, no awvalid; rst_ni low mid-W -> all valids 0
//     same cycle; CSUM_EN: bytes 01..08 -> csum_o 0x0C0A0806.

Source files
------------

// File: rtl/tcm_axi_loader.sv
// Byte-stream to AXI4 INCR write-burst loader for TCM firmware download.
// Optional checksum output enabled by defining TCM_LOADER_CSUM_EN.
module tcm_axi_loader #(
    parameter int unsigned BURST_LEN = 8,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
`ifdef TCM_LOADER_CSUM_EN
    output logic [31:0] csum_o,
`endif
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_base;
    logic [15:0]        r_len;
    logic [15:0]        r_bytes_rcvd;
    logic [15:0]        r_words_sent;
    logic [31:0]        r_pack;
    logic [1:0]         r_pack_cnt;
    logic [31:0]        r_buf [BURST_LEN];
    logic [CNT_W-1:0]   r_buf_cnt;
    logic [IDX_W-1:0]   r_beat;
    logic               r_error;

    logic               w_start;
    logic               w_byte_fire;
    logic               w_last_byte;
    logic               w_word_done;
    logic               w_buf_last_slot;
    logic [31:0]        w_packed;
    logic               w_aw_fire;
    logic               w_w_fire;
    logic               w_b_fire;
    logic               w_beat_last;
    logic               w_all_rcvd;
    logic               w_bresp_err;
    logic [3:0]         w_tail_strb;
    logic               w_unused;

    assign w_unused        = ^axi_bid_i;

    assign w_start         = (r_state == S_IDLE) && start_i;
    assign w_byte_fire     = (r_state == S_FILL) && byte_valid_i;
    assign w_last_byte     = ((r_bytes_rcvd + 16'd1) == r_len);
    assign w_word_done     = (r_pack_cnt == 2'd3) || w_last_byte;
    assign w_buf_last_slot = (r_buf_cnt == CNT_W'(BURST_LEN - 1));
    assign w_packed        = r_pack | ({24'd0, byte_data_i} << {r_pack_cnt, 3'b000});
    assign w_aw_fire       = (r_state == S_AW) && axi_awready_i;
    assign w_w_fire        = (r_state == S_W) && axi_wready_i;
    assign w_b_fire        = (r_state == S_B) && axi_bvalid_i;
    assign w_beat_last     = (CNT_W'(r_beat) == (r_buf_cnt - CNT_W'(1)));
    assign w_all_rcvd      = (r_bytes_rcvd == r_len);
    assign w_bresp_err     = (axi_bresp_i != 2'b00);

    // Byte enables for the final word only cover the bytes actually supplied
    always_comb begin
        w_tail_strb = 4'hF;
        unique case (r_len[1:0])
            2'd1:    w_tail_strb = 4'h1;
            2'd2:    w_tail_strb = 4'h3;
            2'd3:    w_tail_strb = 4'h7;
            default: w_tail_strb = 4'hF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        byte_ready_o  = 1'b0;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_bready_o  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = (len_i == 16'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                byte_ready_o = 1'b1;
                if (w_byte_fire && w_word_done && (w_buf_last_slot || w_last_byte)) begin
                    w_state_nxt = S_AW;
                end
            end
            S_AW: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) begin
                    w_state_nxt = S_W;
                end
            end
            S_W: begin
                axi_wvalid_o = 1'b1;
                if (axi_wready_i && w_beat_last) begin
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    w_state_nxt = (w_bresp_err || w_all_rcvd) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base       <= 32'd0;
            r_len        <= 16'd0;
            r_bytes_rcvd <= 16'd0;
            r_words_sent <= 16'd0;
            r_pack       <= 32'd0;
            r_pack_cnt   <= 2'd0;
            r_buf_cnt    <= '0;
            r_beat       <= '0;
            r_error      <= 1'b0;
        end else begin
            if (w_start) begin
                r_base       <= {base_addr_i[31:2], 2'b00};
                r_len        <= len_i;
                r_bytes_rcvd <= 16'd0;
                r_words_sent <= 16'd0;
                r_pack       <= 32'd0;
                r_pack_cnt   <= 2'd0;
                r_buf_cnt    <= '0;
                r_beat       <= '0;
                r_error      <= 1'b0;
            end
            if (w_byte_fire) begin
                r_bytes_rcvd <= r_bytes_rcvd + 16'd1;
                if (w_word_done) begin
                    r_pack     <= 32'd0;
                    r_pack_cnt <= 2'd0;
                    r_buf_cnt  <= r_buf_cnt + CNT_W'(1);
                end else begin
                    r_pack     <= w_packed;
                    r_pack_cnt <= r_pack_cnt + 2'd1;
                end
            end
            if (w_w_fire) begin
                r_beat <= r_beat + IDX_W'(1);
            end
            // Burst retired: advance the address window and empty the buffer
            if (w_b_fire) begin
                r_words_sent <= r_words_sent + 16'(r_buf_cnt);
                r_buf_cnt    <= '0;
                r_beat       <= '0;
                if (w_bresp_err) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_byte_fire && w_word_done) begin
            r_buf[r_buf_cnt[IDX_W-1:0]] <= w_packed;
        end
    end

    assign axi_awid_o    = AXI_ID;
    assign axi_awburst_o = 2'b01;
    assign axi_awaddr_o  = axi_awvalid_o ? (r_base + {14'd0, r_words_sent, 2'b00}) : 32'd0;
    assign axi_awlen_o   = axi_awvalid_o ? (8'(r_buf_cnt) - 8'd1) : 8'd0;
    assign axi_wdata_o   = axi_wvalid_o ? r_buf[r_beat] : 32'd0;
    assign axi_wstrb_o   = !axi_wvalid_o ? 4'h0 :
                           (w_beat_last && w_all_rcvd) ? w_tail_strb : 4'hF;
    assign axi_wlast_o   = axi_wvalid_o && w_beat_last;
    assign error_o       = r_error;

`ifdef TCM_LOADER_CSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_csum <= 32'd0;
        end else if (w_start) begin
            r_csum <= 32'd0;
        end else if (w_w_fire) begin
            r_csum <= r_csum + axi_wdata_o;
        end
    end

    assign csum_o = r_csum;
`endif

endmodule

// File: tb/tb_tcm_axi_loader.sv
// Randomized bench for tcm_axi_loader against a word/burst-level reference model.
module tb_tcm_axi_loader;

    localparam int          BL  = 8;
    localparam logic [3:0]  AID = 4'hA;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
`ifdef TCM_LOADER_CSUM_EN
    logic [31:0] csum_o;
`endif
    logic        axi_awvalid_o;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_awready_i;
    logic        axi_wvalid_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wlast_o;
    logic        axi_wready_i;
    logic        axi_bvalid_i;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;
    logic        axi_bready_o;

    always #5 clk = ~clk;

    tcm_axi_loader #(.BURST_LEN(BL), .AXI_ID(AID)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
`ifdef TCM_LOADER_CSUM_EN
        .csum_o(csum_o),
`endif
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i),
        .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i), .axi_bready_o(axi_bready_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Shared state between the bus process (source, slave, monitor) and the main sequence
    logic [7:0]  src_q[$];
    logic [31:0] obs_awaddr[$];
    logic [7:0]  obs_awlen[$];
    logic [31:0] obs_wdata[$];
    logic [3:0]  obs_wstrb[$];
    logic        obs_wlast[$];
    int          b_pending = 0;
    int          burst_idx = 0;
    int          err_burst = -1;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_b_cyc = 0;
    int          start_cyc = 0;
    bit          rand_mode = 1'b0;
    bit          aw_stalled = 1'b0;
    bit          w_stalled = 1'b0;
    logic [31:0] aw_hold_addr;
    logic [7:0]  aw_hold_len;
    logic [31:0] w_hold_data;
    logic [3:0]  w_hold_strb;
    logic        w_hold_last;

    initial begin
        byte_valid_i  = 1'b0;
        byte_data_i   = 8'h00;
        axi_awready_i = 1'b0;
        axi_wready_i  = 1'b0;
        axi_bvalid_i  = 1'b0;
        axi_bresp_i   = 2'b00;
        axi_bid_i     = 4'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (src_q.size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
                byte_valid_i = 1'b1;
                byte_data_i  = src_q[0];
            end else begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'h00;
            end
            axi_awready_i = rand_mode ? 1'($urandom_range(1)) : 1'b1;
            axi_wready_i  = rand_mode ? 1'($urandom_range(1)) : 1'b1;
            if (b_pending > 0 && (!rand_mode || $urandom_range(1) == 1)) begin
                axi_bvalid_i = 1'b1;
                axi_bresp_i  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
                axi_bid_i    = 4'($urandom);
            end else begin
                axi_bvalid_i = 1'b0;
                axi_bresp_i  = 2'b00;
            end
            #2;
            if (rst_ni) begin
                if (start_i) start_cyc = cyc;
                if (byte_valid_i && byte_ready_o) void'(src_q.pop_front());
                if (aw_stalled) begin
                    chk("aw_held", 32'(axi_awvalid_o), 32'd1);
                    chk("aw_addr_stable", axi_awaddr_o, aw_hold_addr);
                    chk("aw_len_stable", 32'(axi_awlen_o), 32'(aw_hold_len));
                end
                if (axi_awvalid_o) begin
                    if (axi_awready_i) begin
                        obs_awaddr.push_back(axi_awaddr_o);
                        obs_awlen.push_back(axi_awlen_o);
                        aw_stalled = 1'b0;
                    end else begin
                        aw_stalled   = 1'b1;
                        aw_hold_addr = axi_awaddr_o;
                        aw_hold_len  = axi_awlen_o;
                    end
                end
                if (w_stalled) begin
                    chk("w_held", 32'(axi_wvalid_o), 32'd1);
                    chk("w_data_stable", axi_wdata_o, w_hold_data);
                    chk("w_strb_stable", 32'(axi_wstrb_o), 32'(w_hold_strb));
                    chk("w_last_stable", 32'(axi_wlast_o), 32'(w_hold_last));
                end
                if (axi_wvalid_o) begin
                    if (axi_wready_i) begin
                        obs_wdata.push_back(axi_wdata_o);
                        obs_wstrb.push_back(axi_wstrb_o);
                        obs_wlast.push_back(axi_wlast_o);
                        if (axi_wlast_o) b_pending++;
                        w_stalled = 1'b0;
                    end else begin
                        w_stalled   = 1'b1;
                        w_hold_data = axi_wdata_o;
                        w_hold_strb = axi_wstrb_o;
                        w_hold_last = axi_wlast_o;
                    end
                end
                if (axi_bvalid_i && axi_bready_o) begin
                    b_pending--;
                    burst_idx++;
                    last_b_cyc = cyc;
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_bus();
        src_q.delete();
        b_pending  = 0;
        aw_stalled = 1'b0;
        w_stalled  = 1'b0;
        rand_mode  = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_bus();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic run_load(input string name, input logic [31:0] base, input int len,
                            input int errb, input bit rnd, input bit counting);
        logic [7:0]  ld_bytes[$];
        logic [31:0] abase, exp_addr, d, csum;
        logic [3:0]  strb;
        int nwords, nbursts, bursts_exp, cnt, w, wi, limit, consumed;
        bit exp_err;
        ld_bytes.delete();
        for (int k = 0; k < len; k++) ld_bytes.push_back(counting ? 8'(k + 1) : 8'($urandom));
        obs_awaddr.delete(); obs_awlen.delete();
        obs_wdata.delete(); obs_wstrb.delete(); obs_wlast.delete();
        src_q      = ld_bytes;
        err_burst  = errb;
        burst_idx  = 0;
        done_cnt   = 0;
        last_b_cyc = -100;
        rand_mode  = rnd;
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = 16'(len);
        @(negedge clk);
        start_i     = 1'b0;
        base_addr_i = $urandom;
        len_i       = 16'($urandom);
        limit = 40 * len + 200;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge clk);

        abase      = base & 32'hFFFF_FFFC;
        nwords     = (len + 3) / 4;
        nbursts    = (nwords + BL - 1) / BL;
        exp_err    = (errb >= 0) && (errb < nbursts);
        bursts_exp = exp_err ? errb + 1 : nbursts;
        chk({name, ":done_pulses"}, 32'(done_cnt), 32'd1);
        chk({name, ":aw_count"}, 32'(obs_awaddr.size()), 32'(bursts_exp));
        wi   = 0;
        csum = 32'd0;
        for (int b = 0; b < bursts_exp; b++) begin
            cnt      = ((nwords - b * BL) < BL) ? (nwords - b * BL) : BL;
            exp_addr = abase + 32'(b * BL * 4);
            if (b < obs_awaddr.size()) begin
                chk($sformatf("%s:awaddr[%0d]", name, b), obs_awaddr[b], exp_addr);
                chk($sformatf("%s:awlen[%0d]", name, b), 32'(obs_awlen[b]), 32'(cnt - 1));
            end
            for (int j = 0; j < cnt; j++) begin
                w = b * BL + j;
                d = 32'd0;
                for (int k = 0; k < 4; k++) if (4 * w + k < len) d[8*k +: 8] = ld_bytes[4*w+k];
                strb = (w == nwords - 1 && (len % 4) != 0) ? 4'((1 << (len % 4)) - 1) : 4'hF;
                if (wi < obs_wdata.size()) begin
                    chk($sformatf("%s:wdata[%0d]", name, wi), obs_wdata[wi], d);
                    chk($sformatf("%s:wstrb[%0d]", name, wi), 32'(obs_wstrb[wi]), 32'(strb));
                    chk($sformatf("%s:wlast[%0d]", name, wi), 32'(obs_wlast[wi]), 32'(j == cnt - 1));
                end
                csum += d;
                wi++;
            end
        end
        chk({name, ":w_count"}, 32'(obs_wdata.size()), 32'(wi));
        chk({name, ":error"}, 32'(error_o), 32'(exp_err));
        chk({name, ":busy_idle"}, 32'(busy_o), 32'd0);
        consumed = exp_err ? (((bursts_exp * BL * 4) < len) ? bursts_exp * BL * 4 : len) : len;
        chk({name, ":bytes_left"}, 32'(src_q.size()), 32'(len - consumed));
        if (len == 0) chk({name, ":done_latency"}, 32'(done_cyc), 32'(start_cyc + 1));
        else          chk({name, ":done_latency"}, 32'(done_cyc), 32'(last_b_cyc + 1));
`ifdef TCM_LOADER_CSUM_EN
        chk({name, ":csum"}, csum_o, csum);
`endif
        clear_bus();
        if (done_cnt != 1) do_reset();
    endtask

    initial begin
        int len;
        bit found;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = 32'd0;
        len_i       = 16'd0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst:awvalid", 32'(axi_awvalid_o), 32'd0);
        chk("rst:wvalid", 32'(axi_wvalid_o), 32'd0);
        chk("rst:bready", 32'(axi_bready_o), 32'd0);
        chk("rst:byte_ready", 32'(byte_ready_o), 32'd0);
        chk("rst:busy", 32'(busy_o), 32'd0);
        chk("rst:done", 32'(done_o), 32'd0);
        chk("rst:error", 32'(error_o), 32'd0);
        chk("rst:awburst", 32'(axi_awburst_o), 32'd1);
        chk("rst:awid", 32'(axi_awid_o), 32'(AID));
        chk("rst:awaddr", axi_awaddr_o, 32'd0);
        chk("rst:wdata", axi_wdata_o, 32'd0);
        chk("rst:wlast", 32'(axi_wlast_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        run_load("t1", 32'h0000_0100, 8, -1, 1'b0, 1'b1);
        run_load("t2", 32'h0000_0000, 6, -1, 1'b0, 1'b1);
        run_load("t3", 32'h0000_2000, 80, -1, 1'b0, 1'b0);
        run_load("t4", 32'h0000_1000, 80, 0, 1'b0, 1'b0);
        chk("t4:error_sticky", 32'(error_o), 32'd1);
        run_load("t4b", 32'h0000_3000, 80, 1, 1'b1, 1'b0);
        run_load("t6_len0", 32'h0000_4000, 0, -1, 1'b0, 1'b0);
        run_load("wrap", 32'hFFFF_FFE2, 72, -1, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(100, 1);
            run_load($sformatf("t5_%0d", n), $urandom, len,
                     ($urandom_range(3) == 0) ? $urandom_range(3) : -1, 1'b1, 1'b0);
        end

        // Reset asserted while a burst is in its W phase
        clear_bus();
        for (int k = 0; k < 64; k++) src_q.push_back(8'($urandom));
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = 32'h0000_5000;
        len_i       = 16'd64;
        @(negedge clk);
        start_i = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #3;
            if (axi_wvalid_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("midw:reached", 32'(found), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midw:awvalid", 32'(axi_awvalid_o), 32'd0);
        chk("midw:wvalid", 32'(axi_wvalid_o), 32'd0);
        chk("midw:wlast", 32'(axi_wlast_o), 32'd0);
        chk("midw:bready", 32'(axi_bready_o), 32'd0);
        chk("midw:busy", 32'(busy_o), 32'd0);
        chk("midw:byte_ready", 32'(byte_ready_o), 32'd0);
        clear_bus();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        run_load("post_rst", 32'h0000_0100, 8, -1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
